md5_sched: RTL

MD5_SCHED -- requirements
Module: md5_sched

---
 rtl/md5_sched_if.sv | 32 +++
 rtl/md5_sched.sv | 112 +++++++++++
 2 files changed

// File: rtl/md5_sched_if.sv
// rtl/md5_sched_if.sv - host word stream and hash-core drive signals for md5_sched
// Purpose: bundles the host message-word handshake, the hash-core drive
//          signals and the status outputs of md5_sched.
// Ports (modport slave = md5_sched, master = host/core side):
//   init_i, wvalid_i, wdata_i[0:31]          host -> scheduler
//   wready_o                                 scheduler -> host
//   md5_rst_o, md5_rdy_o, md5_msg_o[0:31]    scheduler -> hash core
//   busy_o, done_o, blk_cnt_o                scheduler status
interface md5_sched_if #(
    parameter int BLKCNT_W = 16
);
    logic                init_i;
    logic                wvalid_i;
    logic [0:31]         wdata_i;
    logic                wready_o;
    logic                md5_rst_o;
    logic                md5_rdy_o;
    logic [0:31]         md5_msg_o;
    logic                busy_o;
    logic                done_o;
    logic [BLKCNT_W-1:0] blk_cnt_o;

    modport master (
        output init_i, wvalid_i, wdata_i,
        input  wready_o, md5_rst_o, md5_rdy_o, md5_msg_o, busy_o, done_o, blk_cnt_o
    );

    modport slave (
        input  init_i, wvalid_i, wdata_i,
        output wready_o, md5_rst_o, md5_rdy_o, md5_msg_o, busy_o, done_o, blk_cnt_o
    );
endinterface

// File: rtl/md5_sched.sv
// rtl/md5_sched.sv - MD5 block buffer and per-round message-word scheduler
// Purpose: collects 16 host words into a block buffer, then strobes an
//          external MD5 core for 64 rounds, feeding the message word each
//          round selects, and pulses done_o once the block is compressed.
// Ports:
//   clk_i  - sole clock, rising edge
//   rst_i  - synchronous active-high reset
//   bus    - md5_sched_if.slave: host word handshake (init_i, wvalid_i,
//            wdata_i, wready_o), core drive (md5_rst_o, md5_rdy_o,
//            md5_msg_o) and status (busy_o, done_o, blk_cnt_o)
module md5_sched #(
    parameter int BLKCNT_W = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    md5_sched_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          wcnt;
    logic [5:0]          r;
    logic [BLKCNT_W-1:0] blk_cnt;
    logic                md5_rst;
    logic [0:31]         msg_buf [16];

    logic                wready;
    logic                accept;
    logic                in_run;
    logic                in_done;
    logic [3:0]          i_idx;
    logic [3:0]          g;

    // Outputs are gated by rst_i so they read idle in the very cycle reset is
    // raised, not only after the first reset edge.
    assign wready  = (state == IDLE) && !bus.init_i && !rst_i;
    assign accept  = bus.wvalid_i && wready;
    assign in_run  = (state == RUN) && !rst_i;
    assign in_done = (state == DONE) && !rst_i;

    assign bus.wready_o  = wready;
    assign bus.md5_rdy_o = in_run;
    assign bus.busy_o    = in_run;
    assign bus.done_o    = in_done;
    assign bus.md5_rst_o = md5_rst;
    assign bus.blk_cnt_o = rst_i ? '0 : blk_cnt;

    always_comb begin
        state_nxt = state;
        if (bus.init_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept && (wcnt == 4'd15)) state_nxt = RUN;
                RUN:     if (r == 6'd63) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.init_i) begin
            wcnt    <= 4'd0;
            r       <= 6'd0;
            blk_cnt <= '0;
        end else begin
            // wcnt wraps 15 -> 0 on the last word, ready for the next block.
            if (accept) wcnt <= wcnt + 4'd1;
            if (accept && (wcnt == 4'd15)) r <= 6'd0;
            else if (state == RUN)         r <= r + 6'd1;
            if (state == DONE) blk_cnt <= blk_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        md5_rst <= rst_i || bus.init_i;
    end

    // Block buffer keeps its contents across reset and init.
    always_ff @(posedge clk_i) begin
        if (accept) msg_buf[wcnt] <= bus.wdata_i;
    end

    // Per-round message index; 4-bit arithmetic gives the mod-16 wrap.
    assign i_idx = r[3:0];
    always_comb begin
        g = i_idx;
        case (r[5:4])
            2'd0: g = i_idx;
            2'd1: g = i_idx * 4'd5 + 4'd1;
            2'd2: g = i_idx * 4'd3 + 4'd5;
            2'd3: g = i_idx * 4'd7;
            default: g = i_idx;
        endcase
    end

    assign bus.md5_msg_o = in_run ? msg_buf[g] : 32'd0;
endmodule
